// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between a core request port and a byte-addressed data memory.
// Latency: a legal request is handshaken at edge N, accessed in cycle N+1 and answered in cycle N+2.
//          An illegal request is answered in cycle N+1 with resp_err=1 and no memory access.
// Backpressure: req_ready is high only in IDLE, so one request is in flight at a time.
//               The response is held stable until resp_ready; the next request is taken a cycle later.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_*                    : core request (valid/ready, we, size, unsigned, addr, wdata)
//   resp_*                   : core response (valid/ready, rdata, err)
//   mem_*                    : memory port (addr, dataW, MemRW, MemSize, MemUnsigned, dataR)
//   busy                     : high whenever the FSM is not in IDLE
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses are rejected with resp_err
//   undefined -> misaligned accesses are passed straight to the byte-addressed memory
module lsu_ctrl #(
  parameter int ADDR_LIMIT = 131072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataW,
  output logic        mem_MemRW,
  output logic [1:0]  mem_MemSize,
  output logic        mem_MemUnsigned,
  input  logic [31:0] mem_dataR,
  output logic        busy
);

  localparam logic [32:0] LIMIT33 = 33'(ADDR_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_hs;
  logic        w_illegal;
  logic        w_misalign;
  logic [2:0]  w_nbytes;
  logic [32:0] w_last;

  // ---------------------------------------------------------------------------
  // Request legality
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nbytes = 3'd4;
    case (req_size)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // Last byte touched, kept in 33 bits so an access that wraps past 2^32 is
  // seen as out of range rather than as a small address.
  assign w_last = {1'b0, req_addr} + {30'b0, w_nbytes} - 33'd1;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_illegal = (req_size == 2'b11) || (w_last >= LIMIT33) || w_misalign;
  assign w_hs      = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_next = w_illegal ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    mem_MemRW  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      // Gated by rst so a reset landing on the ACCESS cycle kills the write
      // edge that would otherwise coincide with the reset edge.
      S_ACCESS: mem_MemRW = r_we && !rst;
      S_RESP:   resp_valid = 1'b1;
      default: begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch and response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_illegal;
        r_rdata <= 32'h0;
      end
      // Loads take the memory's combinational read data on the way out of
      // ACCESS; stores leave the zero written at the handshake.
      if ((r_state == S_ACCESS) && !r_we) begin
        r_rdata <= mem_dataR;
      end
    end
  end

  assign resp_rdata      = r_rdata;
  assign resp_err        = r_err;
  assign mem_addr        = r_addr;
  assign mem_dataW       = r_wdata;
  assign mem_MemSize     = r_size;
  assign mem_MemUnsigned = r_uns;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  localparam int LIMIT = 131072;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_dataW;
  logic        mem_MemRW;
  logic [1:0]  mem_MemSize;
  logic        mem_MemUnsigned;
  logic [31:0] mem_dataR;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;

  logic [7:0] env_mem [0:LIMIT-1];  // memory attached to the DUT
  logic [7:0] ref_mem [0:LIMIT-1];  // expected memory contents

  lsu_ctrl #(.ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_dataW(mem_dataW), .mem_MemRW(mem_MemRW),
    .mem_MemSize(mem_MemSize), .mem_MemUnsigned(mem_MemUnsigned),
    .mem_dataR(mem_dataR), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 151) ^ (i >> 7) ^ 8'h5A);
  endfunction

  // Environment memory: byte addressed, writes on the rising edge, combinational extended read.
  initial begin
    for (int i = 0; i < LIMIT; i++) env_mem[i] = pat(i);
  end

  always @(posedge clk) begin
    if (mem_MemRW) begin
      wr_total <= wr_total + 1;
      for (int i = 0; i < 4; i++) begin
        longint unsigned ix;
        ix = {32'b0, mem_addr} + 64'(i);
        if ((i < ((mem_MemSize == 2'b00) ? 1 : (mem_MemSize == 2'b01) ? 2 : 4)) && (ix < LIMIT))
          env_mem[ix] <= mem_dataW[8*i +: 8];
      end
    end
  end

  always_comb begin
    logic [31:0] raw;
    longint unsigned ix;
    raw = 32'h0;
    for (int i = 0; i < 4; i++) begin
      ix = {32'b0, mem_addr} + 64'(i);
      if (ix < LIMIT) raw[8*i +: 8] = env_mem[ix];
    end
    case (mem_MemSize)
      2'b00:   mem_dataR = mem_MemUnsigned ? {24'b0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'b01:   mem_dataR = mem_MemUnsigned ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: mem_dataR = raw;
    endcase
  end

  // Reference model: decides legality from the rules, returns the expected
  // response and updates the expected memory for accepted stores.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rd, output logic err, output int writes);
    longint unsigned nb;
    longint unsigned a;
    bit legal;
    logic [31:0] v;
    a  = {32'b0, addr};
    nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    legal = (size != 2'b11) && (a + nb <= LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((size == 2'b01) && (a % 2 != 0)) legal = 0;
    if ((size == 2'b10) && (a % 4 != 0)) legal = 0;
`endif
    lat = legal ? 2 : 1;
    err = !legal;
    rd = 32'h0;
    writes = (legal && we) ? 1 : 0;
    if (legal && !we) begin
      v = 32'h0;
      for (int i = 0; i < int'(nb); i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
      if (!uns && v[8 * int'(nb) - 1]) v = v | ~((32'h1 << (8 * int'(nb) - 1) << 1) - 32'h1);
      if (nb == 4) v = v;
      rd = v;
    end
    if (legal && we) begin
      for (int i = 0; i < int'(nb); i++) ref_mem[a + i] = wdata[8*i +: 8];
    end
  endtask

  // Drives one request and observes the response; comparisons live in the callers.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       output int lat, output logic [31:0] rd, output logic err,
                       output int writes, output bit stable, output bit rdy_low);
    int w0;
    int guard;
    w0 = wr_total;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    rdy_low = !req_ready && busy;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      rdy_low = rdy_low && !req_ready && busy;
    end
    rd = resp_rdata; err = resp_err;
    writes = wr_total - w0;
    stable = 1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_rdata !== rd || resp_err !== err || req_ready) stable = 0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++;
    if ({resp_valid, resp_err, busy, mem_MemRW} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {resp_valid, resp_err, busy, mem_MemRW});
    end
    checks++;
    if ({resp_rdata, mem_addr, mem_dataW, mem_MemSize, mem_MemUnsigned} !== 99'b0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h/%b/%b want all 0",
                         resp_rdata, mem_addr, mem_dataW, mem_MemSize, mem_MemUnsigned);
    end
  endtask

  task automatic test_store_load_word();
    int lat, elat, wr, ewr; logic [31:0] rd, erd; logic err, eerr; bit st, rl;
    model(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, elat, erd, eerr, ewr);
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, lat, rd, err, wr, st, rl);
    checks++;
    if (wr !== 1 || err !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL sw_0x10 writes %0d err %b rdata %h want 1 0 0", wr, err, rd);
    end
    model(0, 2'b10, 0, 32'h10, 0, elat, erd, eerr, ewr);
    issue(0, 2'b10, 0, 32'h10, 0, 0, lat, rd, err, wr, st, rl);
    checks++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      errors++; $display("FAIL lw_0x10 rdata %h err %b want deadbeef 0", rd, err);
    end
    checks++;
    if (lat !== 2 || wr !== 0 || !rl) begin
      errors++; $display("FAIL lw_latency lat %0d writes %0d rdylow %b want 2 0 1", lat, wr, rl);
    end
  endtask

  task automatic test_byte_ext();
    int lat, elat, wr, ewr; logic [31:0] rd, erd; logic err, eerr; bit st, rl;
    model(1, 2'b00, 0, 32'h20, 32'h12345680, elat, erd, eerr, ewr);
    issue(1, 2'b00, 0, 32'h20, 32'h12345680, 0, lat, rd, err, wr, st, rl);
    model(0, 2'b00, 0, 32'h20, 0, elat, erd, eerr, ewr);
    issue(0, 2'b00, 0, 32'h20, 0, 1, lat, rd, err, wr, st, rl);
    checks++;
    if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got %h want ffffff80", rd); end
    model(0, 2'b00, 1, 32'h20, 0, elat, erd, eerr, ewr);
    issue(0, 2'b00, 1, 32'h20, 0, 0, lat, rd, err, wr, st, rl);
    checks++;
    if (rd !== 32'h00000080) begin errors++; $display("FAIL lb_unsigned got %h want 00000080", rd); end
  endtask

  task automatic test_out_of_range();
    int lat, elat, wr, ewr; logic [31:0] rd, erd; logic err, eerr; bit st, rl;
    model(0, 2'b10, 0, 32'h0001FFFE, 0, elat, erd, eerr, ewr);
    issue(0, 2'b10, 0, 32'h0001FFFE, 0, 2, lat, rd, err, wr, st, rl);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== 1 || wr !== 0) begin
      errors++; $display("FAIL lw_oob err %b rdata %h lat %0d writes %0d want 1 0 1 0", err, rd, lat, wr);
    end
    model(1, 2'b01, 0, 32'hFFFFFFFF, 32'h1234, elat, erd, eerr, ewr);
    issue(1, 2'b01, 0, 32'hFFFFFFFF, 32'h1234, 0, lat, rd, err, wr, st, rl);
    checks++;
    if (err !== 1'b1 || wr !== 0) begin
      errors++; $display("FAIL sh_wrap err %b writes %0d want 1 0", err, wr);
    end
    model(1, 2'b10, 0, 32'h0001FFFC, 32'hCAFEF00D, elat, erd, eerr, ewr);
    issue(1, 2'b10, 0, 32'h0001FFFC, 32'hCAFEF00D, 0, lat, rd, err, wr, st, rl);
    model(0, 2'b10, 0, 32'h0001FFFC, 0, elat, erd, eerr, ewr);
    issue(0, 2'b10, 0, 32'h0001FFFC, 0, 0, lat, rd, err, wr, st, rl);
    checks++;
    if (err !== 1'b0 || rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL lw_top err %b rdata %h want 0 cafef00d", err, rd);
    end
    model(0, 2'b11, 0, 32'h40, 0, elat, erd, eerr, ewr);
    issue(0, 2'b11, 0, 32'h40, 0, 0, lat, rd, err, wr, st, rl);
    checks++;
    if (err !== 1'b1 || lat !== 1) begin
      errors++; $display("FAIL size11 err %b lat %0d want 1 1", err, lat);
    end
  endtask

  task automatic test_misaligned();
    int lat, elat, wr, ewr; logic [31:0] rd, erd; logic err, eerr; bit st, rl;
    model(0, 2'b01, 0, 32'h21, 0, elat, erd, eerr, ewr);
    issue(0, 2'b01, 0, 32'h21, 0, 0, lat, rd, err, wr, st, rl);
    checks++;
    if (err !== eerr || rd !== erd || lat !== elat) begin
      errors++; $display("FAIL lh_0x21 err %b rdata %h lat %0d want %b %h %0d", err, rd, lat, eerr, erd, elat);
    end
  endtask

  task automatic test_backpressure_and_reset();
    int lat, elat, wr, ewr, w0; logic [31:0] rd, erd; logic err, eerr; bit st, rl;
    model(0, 2'b10, 0, 32'h10, 0, elat, erd, eerr, ewr);
    issue(0, 2'b10, 0, 32'h10, 0, 5, lat, rd, err, wr, st, rl);
    checks++;
    if (!st || rd !== erd) begin
      errors++; $display("FAIL hold5_stable stable %b rdata %h want 1 %h", st, rd, erd);
    end
    // Store to 0x30 aborted by reset during its ACCESS cycle.
    w0 = wr_total;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = ~{ref_mem[32'h33], ref_mem[32'h32], ref_mem[32'h31], ref_mem[32'h30]};
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_MemRW !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_in_access MemRW %b busy %b want 0 1", mem_MemRW, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (wr_total !== w0 ||
        {env_mem[32'h33], env_mem[32'h32], env_mem[32'h31], env_mem[32'h30]} !==
        {ref_mem[32'h33], ref_mem[32'h32], ref_mem[32'h31], ref_mem[32'h30]}) begin
      errors++; $display("FAIL aborted_store writes %0d mem %h want %0d %h", wr_total - w0,
        {env_mem[32'h33], env_mem[32'h32], env_mem[32'h31], env_mem[32'h30]}, 0,
        {ref_mem[32'h33], ref_mem[32'h32], ref_mem[32'h31], ref_mem[32'h30]});
    end
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL after_reset ready %b rvalid %b busy %b addr %h want 1 0 0 0",
                         req_ready, resp_valid, busy, mem_addr);
    end
    // Reset while a response is pending discards it.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_resp rvalid %b rdata %h ready %b want 0 0 1", resp_valid, resp_rdata, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int elat, ewr; logic [31:0] erd, erd2; logic eerr;
    model(0, 2'b10, 0, 32'h10, 0, elat, erd, eerr, ewr);
    model(0, 2'b10, 0, 32'h10, 0, elat, erd2, eerr, ewr);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    resp_ready = 1'b1;
    @(posedge clk); #1;   // ACCESS
    @(posedge clk); #1;   // RESP, consumed this cycle
    checks++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== erd) begin
      errors++; $display("FAIL b2b_resp rvalid %b ready %b rdata %h want 1 0 %h", resp_valid, req_ready, resp_rdata, erd);
    end
    @(posedge clk); #1;   // IDLE again, second request taken at the end of this cycle
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle ready %b rvalid %b want 1 0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== erd2) begin
      errors++; $display("FAIL b2b_second rvalid %b rdata %h want 1 %h", resp_valid, resp_rdata, erd2);
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat, elat, wr, ewr, hold; logic [31:0] rd, erd, addr, wd; logic err, eerr, we, uns;
    logic [1:0] size; bit st, rl;
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 3))
        0:       addr = $urandom_range(0, 255);
        1:       addr = LIMIT - $urandom_range(1, 6);
        2:       addr = $urandom;
        default: addr = $urandom_range(0, LIMIT - 1);
      endcase
      size = 2'($urandom_range(0, 3));
      we = 1'($urandom); uns = 1'($urandom); wd = $urandom;
      hold = $urandom_range(0, 3);
      model(we, size, uns, addr, wd, elat, erd, eerr, ewr);
      issue(we, size, uns, addr, wd, hold, lat, rd, err, wr, st, rl);
      checks++;
      if (rd !== erd || err !== eerr || lat !== elat || wr !== ewr || !st || !rl) begin
        errors++;
        $display("FAIL rand_%0d we %b sz %0d addr %h: rdata %h err %b lat %0d wr %0d st %b rl %b want %h %b %0d %0d 1 1",
                 n, we, size, addr, rd, err, lat, wr, st, rl, erd, eerr, elat, ewr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < LIMIT; i++) ref_mem[i] = pat(i);
    test_reset();
    test_store_load_word();
    test_byte_ext();
    test_out_of_range();
    test_misaligned();
    test_backpressure_and_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
